// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with load formatting and retire counter
// Purpose: latches the MEM-stage instruction, combines it with the memory word
//          returned one cycle later, extracts/extends sub-word loads, flags
//          misaligned loads, drives the register-file write port and counts
//          retired instructions.
// Ports:   clk, reset (async, active-high)
//          stall, flush                - pipeline control
//          in_valid .. in_alu_result   - MEM-stage instruction fields
//          mem_read_data               - synchronous memory read word
//          wb_valid, wb_reg_write, wb_dest, wb_data - register-file write port
//          wb_addr_error               - WB instruction is a misaligned load
//          instret                     - retired-instruction count
module mem_wb_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        in_valid,
  input  logic        in_reg_write,
  input  logic        in_mem_read,
  input  logic [2:0]  in_load_type,
  input  logic [4:0]  in_dest,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] mem_read_data,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic        wb_addr_error,
  output logic [31:0] instret
);

  logic        r_valid;
  logic        r_reg_write;
  logic        r_mem_read;
  logic [2:0]  r_load_type;
  logic [4:0]  r_dest;
  logic [31:0] r_alu_result;
  logic        hold_valid;
  logic [31:0] hold_data;
  logic [31:0] instret_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_load_type  <= 3'd0;
      r_dest       <= 5'd0;
      r_alu_result <= 32'd0;
      hold_valid   <= 1'b0;
      hold_data    <= 32'd0;
      instret_q    <= 32'd0;
    end else if (!stall) begin
      hold_valid <= 1'b0;
      // The instruction leaving WB on an unstalled edge retires here, so a
      // stalled instruction is counted once, on the edge that releases it.
      if (r_valid) begin
        instret_q <= instret_q + 32'd1;
      end
      if (flush || !in_valid) begin
        r_valid      <= 1'b0;
        r_reg_write  <= 1'b0;
        r_mem_read   <= 1'b0;
        r_load_type  <= 3'd0;
        r_dest       <= 5'd0;
        r_alu_result <= 32'd0;
      end else begin
        r_valid      <= 1'b1;
        r_reg_write  <= in_reg_write;
        r_mem_read   <= in_mem_read;
        r_load_type  <= in_load_type;
        r_dest       <= in_dest;
        r_alu_result <= in_alu_result;
      end
    end else if (!hold_valid && r_valid && r_mem_read) begin
      // Memory re-reads the stalled upstream address, so the word belonging
      // to the WB load must be captured on the first stalled edge.
      hold_valid <= 1'b1;
      hold_data  <= mem_read_data;
    end
  end

  logic [31:0] raw;
  logic [1:0]  off;
  logic        is_half;
  logic        is_byte;
  logic        is_signed;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] load_val;
  logic        addr_error;

  always_comb begin
    raw       = hold_valid ? hold_data : mem_read_data;
    off       = r_alu_result[1:0];
    // 101-111 fall through to word loads.
    is_half   = (r_load_type == 3'b001) || (r_load_type == 3'b010);
    is_byte   = (r_load_type == 3'b011) || (r_load_type == 3'b100);
    is_signed = (r_load_type == 3'b001) || (r_load_type == 3'b011);
    half_sel  = off[1] ? raw[31:16] : raw[15:0];
    case (off)
      2'd0:    byte_sel = raw[7:0];
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase
    if (is_byte) begin
      load_val = {{24{is_signed & byte_sel[7]}}, byte_sel};
    end else if (is_half) begin
      load_val = {{16{is_signed & half_sel[15]}}, half_sel};
    end else begin
      load_val = raw;
    end
    if (!r_mem_read) begin
      addr_error = 1'b0;
    end else if (is_byte) begin
      addr_error = 1'b0;
    end else if (is_half) begin
      addr_error = off[0];
    end else begin
      addr_error = |off;
    end
  end

  assign wb_valid      = r_valid;
  assign wb_dest       = r_dest;
  assign wb_data       = r_mem_read ? load_val : r_alu_result;
  assign wb_addr_error = addr_error;
  assign wb_reg_write  = r_valid & r_reg_write & (|r_dest) & ~addr_error;
  assign instret       = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard bench for mem_wb_stage with a reference load model
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_reg_write = 1'b0;
  logic        in_mem_read = 1'b0;
  logic [2:0]  in_load_type = 3'd0;
  logic [4:0]  in_dest = 5'd0;
  logic [31:0] in_alu_result = 32'd0;
  logic [31:0] mem_read_data = 32'd0;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        wb_addr_error;
  logic [31:0] instret;

  mem_wb_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_reg_write  (in_reg_write),
    .in_mem_read   (in_mem_read),
    .in_load_type  (in_load_type),
    .in_dest       (in_dest),
    .in_alu_result (in_alu_result),
    .mem_read_data (mem_read_data),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_dest       (wb_dest),
    .wb_data       (wb_data),
    .wb_addr_error (wb_addr_error),
    .instret       (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  dest;
    logic        rw;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_instret = 32'd0;
  logic        vseen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: access size, little-endian shift and extension computed
  // directly from the load rules with plain arithmetic.
  function automatic exp_t model(input logic rw, input logic mr, input logic [2:0] lt,
                                 input logic [4:0] d, input logic [31:0] alu,
                                 input logic [31:0] word);
    exp_t        e;
    int unsigned size;
    int unsigned shift;
    logic        sgn;
    logic [31:0] mask;
    logic [31:0] v;
    case (lt)
      3'd1:    begin size = 2; sgn = 1'b1; end
      3'd2:    begin size = 2; sgn = 1'b0; end
      3'd3:    begin size = 1; sgn = 1'b1; end
      3'd4:    begin size = 1; sgn = 1'b0; end
      default: begin size = 4; sgn = 1'b0; end
    endcase
    e.err = mr && ((alu % size) != 0);
    if (size == 4)      shift = 0;
    else if (size == 2) shift = 16 * ((alu % 4) / 2);
    else                shift = 8 * (alu % 4);
    mask = (size == 4) ? 32'hFFFF_FFFF : (size == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
    v = (word >> shift) & mask;
    if (sgn && v[8*size-1]) v = v | ~mask;
    e.data = mr ? v : alu;
    e.dest = d;
    e.rw   = rw && (d != 5'd0) && !e.err;
    return e;
  endfunction

  // Monitor: compares the WB slot against the scoreboard head every cycle.
  always @(negedge clk) begin
    if (!reset) begin
      chk("instret", instret, exp_instret);
      vseen = wb_valid;
      if (wb_valid) begin
        if (sb.size() == 0) begin
          chk("wb_valid_unexpected", 32'd1, 32'd0);
        end else begin
          chk("wb_dest", {27'd0, wb_dest}, {27'd0, sb[0].dest});
          chk("wb_data", wb_data, sb[0].data);
          chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, sb[0].rw});
          chk("wb_addr_error", {31'd0, wb_addr_error}, {31'd0, sb[0].err});
        end
      end else begin
        chk("bubble_reg_write", {31'd0, wb_reg_write}, 32'd0);
        chk("bubble_addr_error", {31'd0, wb_addr_error}, 32'd0);
      end
    end
  end

  // The WB instruction retires on any unstalled edge.
  always @(posedge clk) begin
    if (!reset && !stall && vseen) begin
      if (sb.size() > 0) void'(sb.pop_front());
      exp_instret = exp_instret + 32'd1;
    end
  end

  // One cycle of stimulus. word is returned by memory after the edge when
  // the captured instruction is a load; otherwise it is bus garbage.
  task automatic issue(input logic st, input logic fl, input logic v, input logic rw,
                       input logic mr, input logic [2:0] lt, input logic [4:0] d,
                       input logic [31:0] alu, input logic [31:0] word);
    logic cap;
    @(negedge clk);
    stall = st; flush = fl; in_valid = v; in_reg_write = rw; in_mem_read = mr;
    in_load_type = lt; in_dest = d; in_alu_result = alu;
    cap = !st && !fl && v;
    if (cap) sb.push_back(model(rw, mr, lt, d, alu, word));
    @(posedge clk);
    #1;
    mem_read_data = word;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    vseen = 1'b0;
    sb.delete();
    exp_instret = 32'd0;
    repeat (3) begin
      @(negedge clk);
      stall = 1'($urandom); flush = 1'($urandom); in_valid = 1'($urandom);
      in_reg_write = 1'($urandom); in_mem_read = 1'($urandom);
      in_load_type = 3'($urandom); in_dest = 5'($urandom);
      in_alu_result = $urandom; mem_read_data = $urandom;
      #1;
      chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("rst_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
      chk("rst_wb_addr_error", {31'd0, wb_addr_error}, 32'd0);
      chk("rst_wb_dest", {27'd0, wb_dest}, 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_instret", instret, 32'd0);
    end
    stall = 1'b0; flush = 1'b0; in_valid = 1'b0; in_reg_write = 1'b0;
    in_mem_read = 1'b0; in_load_type = 3'd0; in_dest = 5'd0; in_alu_result = 32'd0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic        st, fl, v, mr;
    logic [31:0] alu;
    do_reset();

    // ADD dest=3
    issue(0, 0, 1, 1, 0, 3'd0, 5'd3, 32'h0000_1234, 32'h0);
    // Load extraction from 0x80F17F02
    issue(0, 0, 1, 1, 1, 3'd3, 5'd5, 32'h0000_0103, 32'h80F1_7F02);
    issue(0, 0, 1, 1, 1, 3'd4, 5'd6, 32'h0000_0103, 32'h80F1_7F02);
    issue(0, 0, 1, 1, 1, 3'd1, 5'd7, 32'h0000_0102, 32'h80F1_7F02);
    issue(0, 0, 1, 1, 1, 3'd2, 5'd8, 32'h0000_0100, 32'h80F1_7F02);
    issue(0, 0, 1, 1, 1, 3'd0, 5'd9, 32'h0000_0100, 32'h80F1_7F02);
    // Misalignment
    issue(0, 0, 1, 1, 1, 3'd0, 5'd10, 32'h0000_0006, 32'h1234_5678);
    issue(0, 0, 1, 1, 1, 3'd1, 5'd11, 32'h0000_0001, 32'h1234_5678);
    issue(0, 0, 1, 1, 1, 3'd3, 5'd12, 32'h0000_0001, 32'h1234_5678);
    // LW held across a 3-cycle stall while memory returns other data
    issue(0, 0, 1, 1, 1, 3'd0, 5'd13, 32'h0000_0040, 32'hDEAD_BEEF);
    repeat (3) issue(1, 0, 1, 1, 1, 3'd0, 5'd14, 32'h0000_0080, 32'h1111_1111);
    issue(0, 0, 1, 1, 0, 3'd0, 5'd15, 32'h0000_0777, 32'h0);
    // Flush without stall, then flush with stall
    issue(0, 1, 1, 1, 0, 3'd0, 5'd16, 32'h0000_0999, 32'h0);
    issue(0, 0, 1, 1, 0, 3'd0, 5'd17, 32'h0000_0AAA, 32'h0);
    issue(1, 1, 1, 1, 0, 3'd0, 5'd18, 32'h0000_0BBB, 32'h0);
    // dest=0 write suppressed but counted
    issue(0, 0, 1, 1, 0, 3'd0, 5'd0, 32'h0000_0055, 32'h0);
    // Reset in the middle of a stalled load
    issue(0, 0, 1, 1, 1, 3'd0, 5'd19, 32'h0000_0010, 32'hCAFE_F00D);
    issue(1, 0, 1, 1, 1, 3'd0, 5'd20, 32'h0000_0020, 32'h2222_2222);
    do_reset();
    issue(0, 0, 1, 1, 1, 3'd3, 5'd21, 32'h0000_0002, 32'h00A5_0000);

    for (int i = 0; i < 500; i++) begin
      st  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 7) == 0);
      v   = ($urandom_range(0, 3) != 0);
      mr  = 1'($urandom);
      alu = mr ? {24'd0, 8'($urandom)} : $urandom;
      issue(st, fl, v, 1'($urandom), mr, 3'($urandom), 5'($urandom), alu, $urandom);
    end

    repeat (2) issue(0, 0, 0, 0, 0, 3'd0, 5'd0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
